bike_counter_dec: RTL and testbench

Loadable decrementing counter with a start/busy/done handshake. It is the down-counting counterpart of the barrel-mode incrementing counter. A controller loads an initial value and the block counts down to zero on enabled cycles. At zero it either finishes with a one-cycle done pulse (one-shot) or reloads and keeps running (barrel mode). It sits beside the decoder and multiplier control FSMs to bound iteration loops and timeouts.

---
 rtl/bike_counter_pkg.sv | 11 +
 rtl/bike_counter_dec.sv | 100 ++++++++++
 tb/tb_bike_counter_dec.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bike_counter_pkg.sv
// Shared types for the bike counter family: FSM state encoding and mode constants.
package bike_counter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_BARREL  = 1'b1;
endpackage

// File: rtl/bike_counter_dec.sv
// Loadable down-counter with start/busy/done handshake; one-shot or barrel (auto-reload) mode.
module bike_counter_dec
  import bike_counter_pkg::*;
#(
  parameter int SIZE      = 5,
  parameter int MAX_VALUE = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] load_val,
  input  logic            mode,
  input  logic            enable,
  input  logic            abort,
  output logic [SIZE-1:0] cnt_out,
  output logic            busy,
  output logic            done,
  output logic            wrap
);

  localparam logic [SIZE-1:0] MAX_V = SIZE'(MAX_VALUE);

  cnt_state_t      state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] reload_q, reload_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wrap_q, wrap_d;
  logic [SIZE-1:0] load_sat;

  assign load_sat = (load_val > MAX_V) ? MAX_V : load_val;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (enable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - SIZE'(1);
          end else if (mode_q == MODE_BARREL) begin
            cnt_d  = reload_q;
            wrap_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE share load handling; DONE accepts start for back-to-back runs.
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start) begin
          state_d  = RUN;
          cnt_d    = load_sat;
          reload_d = load_sat;
          mode_d   = mode;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign cnt_out = cnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bike_counter_dec.sv
// Directed bench for bike_counter_dec (SIZE=5, MAX_VALUE=20).
module tb_bike_counter_dec;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] load_val;
  logic       mode;
  logic       enable;
  logic       abort;
  logic [4:0] cnt_out;
  logic       busy, done, wrap;

  int errors = 0;
  int checks = 0;

  bike_counter_dec #(.SIZE(5), .MAX_VALUE(20)) dut (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val), .mode(mode),
    .enable(enable), .abort(abort), .cnt_out(cnt_out), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; enable = 0; mode = 0; load_val = '0;
  endtask

  task automatic do_start(input logic [4:0] v, input logic m);
    start = 1; load_val = v; mode = m;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    tick();
    checks++;
    if ({cnt_out, busy, done, wrap} !== 8'b0) begin
      errors++; $display("FAIL reset_state: got cnt=%0d busy=%b done=%b wrap=%b, need all 0", cnt_out, busy, done, wrap);
    end
    reset = 0;
    tick();
    do_start(5'd7, 1'b0);
    enable = 1;
    repeat (3) tick();
    checks++;
    if (cnt_out !== 5'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_precount: got cnt=%0d busy=%b, need 4/1", cnt_out, busy);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (cnt_out !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_async: got cnt=%0d busy=%b done=%b, need 0/0/0", cnt_out, busy, done);
    end
    tick();
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (cnt_out !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL reset_stays_idle: cyc %0d cnt=%0d busy=%b done=%b, need 0/0/0", i, cnt_out, busy, done);
      end
    end
    enable = 0;
  endtask

  task automatic test_oneshot();
    logic [4:0] exp [4];
    exp = '{5'd3, 5'd2, 5'd1, 5'd0};
    enable = 1;
    do_start(5'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt_out !== exp[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL oneshot_seq: step %0d cnt=%0d busy=%b done=%b, need %0d/1/0", i, cnt_out, busy, done, exp[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt_out !== 5'd0) begin
      errors++; $display("FAIL oneshot_done: done=%b busy=%b cnt=%0d, need 1/0/0", done, busy, cnt_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL oneshot_idle: done=%b busy=%b, need 0/0", done, busy);
    end
    enable = 0;
  endtask

  task automatic test_saturation();
    int en_cnt = 0;
    logic [4:0] prev;
    bit finished = 0;
    do_start(5'd31, 1'b0);
    checks++;
    if (cnt_out !== 5'd20) begin
      errors++; $display("FAIL sat_load: cnt=%0d, need 20", cnt_out);
    end
    for (int i = 0; i < 100 && !finished; i++) begin
      enable = i[0];
      prev = cnt_out;
      tick();
      if (enable) en_cnt++;
      if (done) finished = 1;
      else if (!enable && cnt_out !== prev) begin
        checks++; errors++;
        $display("FAIL sat_hold: cycle %0d cnt=%0d, need %0d", i, cnt_out, prev);
      end
    end
    checks++;
    if (!finished || en_cnt != 21) begin
      errors++; $display("FAIL sat_length: finished=%0d enabled_cycles=%0d, need 1/21", finished, en_cnt);
    end
    enable = 0;
    tick();
  endtask

  task automatic test_barrel();
    logic [4:0] exp [6];
    logic       expw [6];
    exp  = '{5'd1, 5'd0, 5'd2, 5'd1, 5'd0, 5'd2};
    expw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_start(5'd2, 1'b1);
    mode = 0;
    checks++;
    if (cnt_out !== 5'd2 || busy !== 1'b1 || wrap !== 1'b0) begin
      errors++; $display("FAIL barrel_load: cnt=%0d busy=%b wrap=%b, need 2/1/0", cnt_out, busy, wrap);
    end
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (cnt_out !== exp[i] || wrap !== expw[i] || done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL barrel_seq: step %0d cnt=%0d wrap=%b done=%b busy=%b, need %0d/%b/0/1",
                           i, cnt_out, wrap, done, busy, exp[i], expw[i]);
      end
    end
    abort = 1; enable = 0;
    tick();
    abort = 0;
  endtask

  task automatic test_abort_and_b2b();
    do_start(5'd5, 1'b0);
    abort = 1; start = 1; load_val = 5'd9;
    tick();
    abort = 0; start = 0;
    checks++;
    if (cnt_out !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL abort_run: cnt=%0d busy=%b done=%b wrap=%b, need 0/0/0/0", cnt_out, busy, done, wrap);
    end
    abort = 1; start = 1; load_val = 5'd4;
    tick();
    abort = 0; start = 0;
    checks++;
    if (busy !== 1'b0 || cnt_out !== 5'd0) begin
      errors++; $display("FAIL abort_idle_start: busy=%b cnt=%0d, need 0/0", busy, cnt_out);
    end
    do_start(5'd1, 1'b0);
    enable = 1;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done: done=%b busy=%b, need 1/0", done, busy);
    end
    enable = 0;
    do_start(5'd1, 1'b0);
    checks++;
    if (busy !== 1'b1 || cnt_out !== 5'd1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: busy=%b cnt=%0d done=%b, need 1/1/0", busy, cnt_out, done);
    end
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic test_zero();
    do_start(5'd0, 1'b0);
    checks++;
    if (busy !== 1'b1 || cnt_out !== 5'd0) begin
      errors++; $display("FAIL zero_load: busy=%b cnt=%0d, need 1/0", busy, cnt_out);
    end
    enable = 1;
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_oneshot: done=%b busy=%b, need 1/0", done, busy);
    end
    enable = 0;
    do_start(5'd0, 1'b1);
    enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wrap !== 1'b1 || cnt_out !== 5'd0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL zero_barrel: step %0d wrap=%b cnt=%0d busy=%b done=%b, need 1/0/1/0", i, wrap, cnt_out, busy, done);
      end
    end
    enable = 0;
    tick();
    checks++;
    if (wrap !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_barrel_gap: wrap=%b busy=%b, need 0/1", wrap, busy);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_saturation();
    test_barrel();
    test_abort_and_b2b();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
